// File: rtl/vector_mem_ctrl_pkg.sv
// Shared types for the strided vector memory sequencer.
package vector_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/vmem_addr_gen.sv
// Address accumulator and iteration counter for one vector command.
module vmem_addr_gen #(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [CNT_WIDTH-1:0]  count_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, stride_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // Address wraps silently modulo 2^ADDR_WIDTH.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = base_i;
            cnt_d  = count_i;
        end else if (step_i) begin
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q   <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            if (load_i) stride_q <= stride_i;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == CNT_WIDTH'(1));

endmodule

// File: rtl/vector_mem_ctrl.sv
// Strided vector load/store sequencer for the NUM_ELEM-bank vector memory.
// Optional perf counters: define VECTOR_MEM_CTRL_PERF_EN.
module vector_mem_ctrl
    import vector_mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int ADDR_WIDTH   = 12,
    parameter int NUM_ELEM     = 16,
    parameter int CNT_WIDTH    = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic                           cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]          cmd_base_i,
    input  logic [ADDR_WIDTH-1:0]          cmd_stride_i,
    input  logic [CNT_WIDTH-1:0]           cmd_count_i,
    input  logic [NUM_ELEM-1:0]            cmd_mask_i,
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [DATA_WIDTH*NUM_ELEM-1:0] wr_data_i,
    output logic                           rd_valid_o,
    output logic                           rd_last_o,
    output logic [DATA_WIDTH*NUM_ELEM-1:0] rd_data_o,
    output logic [NUM_ELEM-1:0]            mem_read_req_o,
    output logic [ADDR_WIDTH*NUM_ELEM-1:0] mem_read_addr_o,
    input  logic [DATA_WIDTH*NUM_ELEM-1:0] mem_read_data_i,
    output logic [NUM_ELEM-1:0]            mem_write_req_o,
    output logic [ADDR_WIDTH*NUM_ELEM-1:0] mem_write_addr_o,
    output logic [DATA_WIDTH*NUM_ELEM-1:0] mem_write_data_o,
    output logic                           busy_o,
    output logic                           done_o
`ifdef VECTOR_MEM_CTRL_PERF_EN
    ,
    output logic [31:0]                    perf_busy_cycles_o,
    output logic [31:0]                    perf_stall_cycles_o
`endif
);

    state_e                         state_q, state_d;
    logic                           op_q;
    logic [NUM_ELEM-1:0]            mask_q;
    logic [DATA_WIDTH*NUM_ELEM-1:0] wr_hold_q;
    logic [READ_LATENCY:1]          vld_pipe_q, last_pipe_q;
    logic                           load, step, last, rd_issue, wr_fire;
    logic [ADDR_WIDTH-1:0]          cur_addr;

    vmem_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_addr_gen (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (load),
        .step_i   (step),
        .base_i   (cmd_base_i),
        .stride_i (cmd_stride_i),
        .count_i  (cmd_count_i),
        .addr_o   (cur_addr),
        .last_o   (last)
    );

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        step        = 1'b0;
        rd_issue    = 1'b0;
        wr_fire     = 1'b0;
        cmd_ready_o = 1'b0;
        wr_ready_o  = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    load    = 1'b1;
                    state_d = (cmd_count_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (op_q == OP_READ) begin
                    rd_issue = 1'b1;
                    step     = 1'b1;
                    if (last) state_d = DRAIN;
                end else begin
                    wr_ready_o = 1'b1;
                    if (wr_valid_i) begin
                        wr_fire = 1'b1;
                        step    = 1'b1;
                        if (last) state_d = DONE;
                    end
                end
            end
            DRAIN: if (rd_valid_o && rd_last_o) state_d = DONE;
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            mask_q      <= '0;
            wr_hold_q   <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q   <= cmd_op_i;
                mask_q <= cmd_mask_i;
            end
            if (wr_fire) wr_hold_q <= wr_data_i;
            // Return-path tracker: one stage per cycle of memory read latency.
            vld_pipe_q[1]  <= rd_issue;
            last_pipe_q[1] <= rd_issue & last;
            for (int k = 2; k <= READ_LATENCY; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1];
                last_pipe_q[k] <= last_pipe_q[k-1];
            end
        end
    end

    assign rd_valid_o = vld_pipe_q[READ_LATENCY];
    assign rd_last_o  = last_pipe_q[READ_LATENCY];
    assign rd_data_o  = mem_read_data_i;
    assign busy_o     = (state_q != IDLE);

    assign mem_read_req_o   = rd_issue ? mask_q : '0;
    assign mem_write_req_o  = wr_fire  ? mask_q : '0;
    // Idle write data holds the last beat so the bank inputs don't toggle.
    assign mem_write_data_o = wr_fire  ? wr_data_i : wr_hold_q;

    for (genvar g = 0; g < NUM_ELEM; g++) begin : g_lane
        assign mem_read_addr_o[g*ADDR_WIDTH +: ADDR_WIDTH]  = cur_addr;
        assign mem_write_addr_o[g*ADDR_WIDTH +: ADDR_WIDTH] = cur_addr;
    end

`ifdef VECTOR_MEM_CTRL_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_o && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
            if (state_q == RUN && op_q == OP_WRITE && !wr_valid_i && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_busy_cycles_o  = perf_busy_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule
